// File: rtl/axi_conf.sv
// AXI4 channel structs for the DMA-to-memory port.
// req_t/resp_t bundle all five channels with handshakes.
package axi_conf;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned UserWidth = 2;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;
  typedef logic [7:0]             len_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_io_pmp_pkg.sv
// Shared types for the IO-PMP enforcement gate.
// FSM state enums and the default error response.
package axi_io_pmp_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FWD,
    W_DRAIN,
    W_BERR
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FWD,
    R_ERR
  } r_state_e;

  localparam axi_pkg::resp_t ERR_RESP = axi_pkg::RESP_SLVERR;

endpackage

// File: rtl/axi_pkg.sv
// AXI4 protocol constants shared by the interconnect.
// Provides the response-code type and its encodings.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_io_pmp_rd_err.sv
// Error R-burst generator for terminated reads: captures id/user/len
// on start_i, emits len+1 zero-data beats while active_i, done_o on last.
module axi_io_pmp_rd_err
  import axi_io_pmp_pkg::*;
#(
  parameter axi_pkg::resp_t ErrResp = ERR_RESP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  axi_conf::id_t     id_i,
  input  axi_conf::user_t   user_i,
  input  axi_conf::len_t    len_i,
  input  logic              active_i,
  input  logic              ready_i,
  output logic              valid_o,
  output axi_conf::r_chan_t r_o,
  output logic              done_o
);

  axi_conf::id_t   id_q;
  axi_conf::user_t user_q;
  axi_conf::len_t  len_q;
  logic [7:0]      cnt_q;
  logic            last;

  assign last    = (cnt_q == len_q);
  assign valid_o = active_i;
  assign done_o  = active_i & ready_i & last;

  always_comb begin
    r_o      = '0;
    r_o.id   = id_q;
    r_o.resp = ErrResp;
    r_o.last = last;
    r_o.user = user_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q   <= '0;
      user_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      id_q   <= id_i;
      user_q <= user_i;
      len_q  <= len_i;
      cnt_q  <= '0;
    end else if (active_i && ready_i && !last) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/axi_io_pmp_gate.sv
// IO-PMP enforcement gate: forwards allowed AXI transactions, terminates
// denied ones with error B/R; counts denials (deny_cnt_o, saturating).
module axi_io_pmp_gate
  import axi_io_pmp_pkg::*;
#(
  parameter axi_pkg::resp_t ErrResp  = ERR_RESP,
  parameter int unsigned    CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  axi_conf::req_t      slv_req_i,
  output axi_conf::resp_t     slv_resp_o,
  output axi_conf::req_t      mst_req_o,
  input  axi_conf::resp_t     mst_resp_i,
  input  logic                aw_allow_i,
  input  logic                ar_allow_i,
  output logic [CntWidth-1:0] deny_cnt_o
);

  w_state_e          w_q;
  r_state_e          r_q;
  axi_conf::id_t     aw_id_q;
  axi_conf::user_t   aw_user_q;
  logic              aw_ok;
  logic              ar_ok;
  logic              aw_hs;
  logic              ar_hs;
  logic              aw_deny;
  logic              ar_deny;
  logic              err_valid;
  logic              err_done;
  axi_conf::r_chan_t err_r;
  logic [1:0]        deny_inc;
  logic [CntWidth:0] deny_sum;
  logic [CntWidth-1:0] cnt_q;

  // Atomics are never forwarded; they take the error path.
  assign aw_ok = aw_allow_i & (slv_req_i.aw.atop == 6'd0);
  assign ar_ok = ar_allow_i;

  assign aw_hs = (w_q == W_IDLE) & slv_req_i.aw_valid
               & (aw_ok ? mst_resp_i.aw_ready : 1'b1);
  assign ar_hs = (r_q == R_IDLE) & slv_req_i.ar_valid
               & (ar_ok ? mst_resp_i.ar_ready : 1'b1);

  assign aw_deny = aw_hs & ~aw_ok;
  assign ar_deny = ar_hs & ~ar_ok;

  axi_io_pmp_rd_err #(
    .ErrResp (ErrResp)
  ) u_rd_err (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (ar_deny),
    .id_i     (slv_req_i.ar.id),
    .user_i   (slv_req_i.ar.user),
    .len_i    (slv_req_i.ar.len),
    .active_i (r_q == R_ERR),
    .ready_i  (slv_req_i.r_ready),
    .valid_o  (err_valid),
    .r_o      (err_r),
    .done_o   (err_done)
  );

  always_comb begin
    mst_req_o    = '0;
    mst_req_o.aw = slv_req_i.aw;
    mst_req_o.w  = slv_req_i.w;
    mst_req_o.ar = slv_req_i.ar;
    slv_resp_o   = '0;
    slv_resp_o.b = mst_resp_i.b;
    slv_resp_o.r = mst_resp_i.r;

    unique case (w_q)
      W_IDLE: begin
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_ok;
        slv_resp_o.aw_ready = aw_ok ? mst_resp_i.aw_ready : 1'b1;
      end
      W_FWD: begin
        mst_req_o.w_valid  = slv_req_i.w_valid;
        slv_resp_o.w_ready = mst_resp_i.w_ready;
        slv_resp_o.b_valid = mst_resp_i.b_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
      end
      W_DRAIN: begin
        slv_resp_o.w_ready = 1'b1;
      end
      W_BERR: begin
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b.id    = aw_id_q;
        slv_resp_o.b.resp  = ErrResp;
        slv_resp_o.b.user  = aw_user_q;
      end
      default: ;
    endcase

    unique case (r_q)
      R_IDLE: begin
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_ok;
        slv_resp_o.ar_ready = ar_ok ? mst_resp_i.ar_ready : 1'b1;
      end
      R_FWD: begin
        slv_resp_o.r_valid = mst_resp_i.r_valid;
        mst_req_o.r_ready  = slv_req_i.r_ready;
      end
      R_ERR: begin
        slv_resp_o.r_valid = err_valid;
        slv_resp_o.r       = err_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_q       <= W_IDLE;
      aw_id_q   <= '0;
      aw_user_q <= '0;
    end else begin
      unique case (w_q)
        W_IDLE: begin
          if (aw_hs) begin
            w_q <= aw_ok ? W_FWD : W_DRAIN;
          end
          if (aw_deny) begin
            aw_id_q   <= slv_req_i.aw.id;
            aw_user_q <= slv_req_i.aw.user;
          end
        end
        W_FWD: begin
          if (mst_resp_i.b_valid && slv_req_i.b_ready) begin
            w_q <= W_IDLE;
          end
        end
        W_DRAIN: begin
          if (slv_req_i.w_valid && slv_req_i.w.last) begin
            w_q <= W_BERR;
          end
        end
        W_BERR: begin
          if (slv_req_i.b_ready) begin
            w_q <= W_IDLE;
          end
        end
        default: w_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= R_IDLE;
    end else begin
      unique case (r_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_q <= ar_ok ? R_FWD : R_ERR;
          end
        end
        R_FWD: begin
          if (mst_resp_i.r_valid && slv_req_i.r_ready
              && mst_resp_i.r.last) begin
            r_q <= R_IDLE;
          end
        end
        R_ERR: begin
          if (err_done) begin
            r_q <= R_IDLE;
          end
        end
        default: r_q <= R_IDLE;
      endcase
    end
  end

  // One extra bit catches the carry so the counter sticks at all-ones.
  assign deny_inc = {1'b0, aw_deny} + {1'b0, ar_deny};
  assign deny_sum = {1'b0, cnt_q}
                  + {{(CntWidth-1){1'b0}}, deny_inc};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (deny_sum[CntWidth]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= deny_sum[CntWidth-1:0];
    end
  end

  assign deny_cnt_o = cnt_q;

  atop_unsupported: cover property (
    @(posedge clk_i) disable iff (rst_i)
    slv_req_i.aw_valid && slv_req_i.aw.atop[5]
  );

endmodule

// File: tb/tb_axi_io_pmp_gate.sv
// Directed bench for axi_io_pmp_gate: forward, deny, saturation,
// atop and mid-burst reset; a 2-bit counter twin checks saturation.
module tb_axi_io_pmp_gate;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  axi_conf::req_t  slv_req;
  axi_conf::resp_t slv_resp;
  axi_conf::req_t  mst_req;
  axi_conf::resp_t mst_resp;
  axi_conf::resp_t slv_resp2;
  axi_conf::req_t  mst_req2;
  logic            aw_allow;
  logic            ar_allow;
  logic [31:0]     deny_cnt;
  logic [1:0]      deny_sat;
  int              n_chk = 0;
  int              n_err = 0;
  int              beats;

  always #5 clk = ~clk;

  axi_io_pmp_gate dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .aw_allow_i (aw_allow),
    .ar_allow_i (ar_allow),
    .deny_cnt_o (deny_cnt)
  );

  axi_io_pmp_gate #(
    .CntWidth (2)
  ) dut_sat (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp2),
    .mst_req_o  (mst_req2),
    .mst_resp_i (mst_resp),
    .aw_allow_i (aw_allow),
    .ar_allow_i (ar_allow),
    .deny_cnt_o (deny_sat)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    aw_allow = 1'b0;
    ar_allow = 1'b0;
    rst      = 1'b1;
    repeat (2) tick;
    check("rst_cnt", deny_cnt, 0);
    check("rst_bvalid", slv_resp.b_valid, 0);
    check("rst_rvalid", slv_resp.r_valid, 0);
    check("rst_mst_awv", mst_req.aw_valid, 0);
    rst = 1'b0;
    tick;

    // allowed write
    slv_req.aw.id      = 4'd1;
    slv_req.aw.addr    = 32'h1000;
    slv_req.aw_valid   = 1'b1;
    aw_allow           = 1'b1;
    mst_resp.aw_ready  = 1'b1;
    #1;
    check("fwd_awvalid", mst_req.aw_valid, 1);
    check("fwd_awaddr", mst_req.aw.addr, 32'h1000);
    check("fwd_awready", slv_resp.aw_ready, 1);
    tick;
    slv_req.aw_valid  = 1'b0;
    aw_allow          = 1'b0;
    mst_resp.aw_ready = 1'b0;
    slv_req.w.data    = 32'hdeadbeef;
    slv_req.w.last    = 1'b1;
    slv_req.w_valid   = 1'b1;
    mst_resp.w_ready  = 1'b1;
    #1;
    check("fwd_wvalid", mst_req.w_valid, 1);
    check("fwd_wdata", mst_req.w.data, 32'hdeadbeef);
    check("fwd_wready", slv_resp.w_ready, 1);
    tick;
    slv_req.w_valid   = 1'b0;
    slv_req.w.last    = 1'b0;
    mst_resp.w_ready  = 1'b0;
    mst_resp.b_valid  = 1'b1;
    mst_resp.b.id     = 4'd1;
    mst_resp.b.resp   = 2'b00;
    slv_req.b_ready   = 1'b1;
    #1;
    check("fwd_bvalid", slv_resp.b_valid, 1);
    check("fwd_bid", slv_resp.b.id, 1);
    check("fwd_bresp", slv_resp.b.resp, 0);
    check("fwd_bready", mst_req.b_ready, 1);
    tick;
    mst_resp.b_valid = 1'b0;
    slv_req.b_ready  = 1'b0;

    // allowed read
    slv_req.ar.id     = 4'd3;
    slv_req.ar.addr   = 32'h1000;
    slv_req.ar_valid  = 1'b1;
    ar_allow          = 1'b1;
    mst_resp.ar_ready = 1'b1;
    #1;
    check("fwd_arvalid", mst_req.ar_valid, 1);
    check("fwd_araddr", mst_req.ar.addr, 32'h1000);
    check("fwd_arready", slv_resp.ar_ready, 1);
    tick;
    slv_req.ar_valid  = 1'b0;
    ar_allow          = 1'b0;
    mst_resp.ar_ready = 1'b0;
    mst_resp.r_valid  = 1'b1;
    mst_resp.r.id     = 4'd3;
    mst_resp.r.data   = 32'hcafef00d;
    mst_resp.r.last   = 1'b1;
    slv_req.r_ready   = 1'b1;
    #1;
    check("fwd_rvalid", slv_resp.r_valid, 1);
    check("fwd_rdata", slv_resp.r.data, 32'hcafef00d);
    check("fwd_rready", mst_req.r_ready, 1);
    tick;
    mst_resp.r_valid = 1'b0;
    mst_resp.r       = '0;
    slv_req.r_ready  = 1'b0;
    #1;
    check("fwd_cnt", deny_cnt, 0);

    // W before AW is stalled
    slv_req.w_valid = 1'b1;
    #1;
    check("stall_wready", slv_resp.w_ready, 0);
    check("stall_mst_wv", mst_req.w_valid, 0);

    // denied write, 4 beats
    slv_req.aw.id    = 4'd5;
    slv_req.aw.len   = 8'd3;
    slv_req.aw.user  = 2'd1;
    slv_req.aw_valid = 1'b1;
    #1;
    check("dw_mst_awv", mst_req.aw_valid, 0);
    check("dw_awready", slv_resp.aw_ready, 1);
    tick;
    slv_req.aw_valid = 1'b0;
    check("dw_cnt1", deny_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      slv_req.w.last = (i == 3);
      #1;
      check("dw_wready", slv_resp.w_ready, 1);
      check("dw_mst_wv", mst_req.w_valid, 0);
      check("dw_bvalid", slv_resp.b_valid, 0);
      tick;
    end
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    #1;
    check("dw_berr_v", slv_resp.b_valid, 1);
    check("dw_berr_id", slv_resp.b.id, 5);
    check("dw_berr_resp", slv_resp.b.resp, 2'b10);
    check("dw_berr_user", slv_resp.b.user, 1);
    check("dw_mst_bready", mst_req.b_ready, 0);
    tick;
    check("dw_hold_v", slv_resp.b_valid, 1);
    check("dw_hold_id", slv_resp.b.id, 5);
    slv_req.b_ready = 1'b1;
    tick;
    slv_req.b_ready = 1'b0;
    #1;
    check("dw_b_done", slv_resp.b_valid, 0);
    check("dw_cnt", deny_cnt, 1);

    // denied read, 8 beats, r_ready toggling
    slv_req.ar.id    = 4'd2;
    slv_req.ar.len   = 8'd7;
    slv_req.ar.user  = 2'd0;
    slv_req.ar_valid = 1'b1;
    #1;
    check("dr_mst_arv", mst_req.ar_valid, 0);
    check("dr_arready", slv_resp.ar_ready, 1);
    tick;
    slv_req.ar_valid = 1'b0;
    check("dr_mst_rready", mst_req.r_ready, 0);
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      slv_req.r_ready = c[0];
      #1;
      check("dr_valid", slv_resp.r_valid, 1);
      check("dr_data", slv_resp.r.data, 0);
      check("dr_resp", slv_resp.r.resp, 2'b10);
      check("dr_id", slv_resp.r.id, 2);
      check("dr_last", slv_resp.r.last, (beats == 7));
      if (slv_resp.r_valid && slv_req.r_ready) beats++;
      tick;
    end
    check("dr_beats", beats, 8);
    slv_req.r_ready = 1'b0;
    #1;
    check("dr_done", slv_resp.r_valid, 0);
    check("dr_cnt", deny_cnt, 2);
    check("dr_sat", deny_sat, 2);

    // denied AW and AR in the same cycle
    slv_req.aw.id    = 4'd6;
    slv_req.aw.len   = 8'd0;
    slv_req.aw_valid = 1'b1;
    slv_req.ar.id    = 4'd7;
    slv_req.ar.len   = 8'd0;
    slv_req.ar_valid = 1'b1;
    #1;
    check("both_cnt_pre", deny_cnt, 2);
    tick;
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    check("both_cnt", deny_cnt, 4);
    check("both_sat", deny_sat, 3);
    slv_req.w_valid = 1'b1;
    slv_req.w.last  = 1'b1;
    slv_req.r_ready = 1'b1;
    #1;
    check("both_rvalid", slv_resp.r_valid, 1);
    check("both_rlast", slv_resp.r.last, 1);
    check("both_rid", slv_resp.r.id, 7);
    tick;
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    slv_req.r_ready = 1'b0;
    slv_req.b_ready = 1'b1;
    #1;
    check("both_bvalid", slv_resp.b_valid, 1);
    check("both_bid", slv_resp.b.id, 6);
    check("both_r_done", slv_resp.r_valid, 0);
    tick;
    slv_req.b_ready = 1'b0;

    // atomic with allow=1 is denied
    slv_req.aw.id     = 4'd9;
    slv_req.aw.atop   = 6'h20;
    slv_req.aw_valid  = 1'b1;
    aw_allow          = 1'b1;
    mst_resp.aw_ready = 1'b1;
    #1;
    check("atop_mst_awv", mst_req.aw_valid, 0);
    check("atop_awready", slv_resp.aw_ready, 1);
    tick;
    slv_req.aw_valid  = 1'b0;
    slv_req.aw.atop   = 6'h0;
    aw_allow          = 1'b0;
    mst_resp.aw_ready = 1'b0;
    slv_req.w_valid   = 1'b1;
    slv_req.w.last    = 1'b1;
    #1;
    check("atop_mst_wv", mst_req.w_valid, 0);
    tick;
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    slv_req.b_ready = 1'b1;
    #1;
    check("atop_bvalid", slv_resp.b_valid, 1);
    check("atop_bresp", slv_resp.b.resp, 2'b10);
    check("atop_bid", slv_resp.b.id, 9);
    tick;
    slv_req.b_ready = 1'b0;
    check("atop_cnt", deny_cnt, 5);
    check("atop_sat", deny_sat, 3);

    // reset in the middle of an error read burst
    slv_req.ar.id    = 4'd4;
    slv_req.ar.len   = 8'd7;
    slv_req.ar_valid = 1'b1;
    tick;
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_burst_v", slv_resp.r_valid, 1);
      tick;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_rv", slv_resp.r_valid, 0);
    check("rst_mid_cnt", deny_cnt, 0);
    check("rst_mid_sat", deny_sat, 0);
    tick;
    rst             = 1'b0;
    slv_req.r_ready = 1'b0;
    #1;
    check("rst_after_rv", slv_resp.r_valid, 0);
    check("rst_after_idle", slv_resp.ar_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_io_pmp_gate.md
# axi_io_pmp_gate

AXI4 enforcement stage sitting directly downstream of the IO-PMP address checker and upstream of the memory-side crossbar port. It forwards transactions the checker allows and terminates denied ones locally with AXI error responses: W beats drained, B or R beats generated. The upstream master therefore always sees a protocol-correct completion. It operates on the `axi_conf::req_t`/`resp_t` channel structs and admits one outstanding transaction per direction.

## Interface
- `ErrResp`, default `axi_pkg::RESP_SLVERR`: resp code returned on denied transactions.
- `CntWidth`, default 32: width of the denial counter.

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `slv_req_i`  in  `axi_conf::req_t`  request from the upstream DMA master.
- `slv_resp_o`  out  `axi_conf::resp_t`  response to the upstream master.
- `mst_req_o`  out  `axi_conf::req_t`  request to downstream memory.
- `mst_resp_i`  in  `axi_conf::resp_t`  response from downstream memory.
- `aw_allow_i`  in  1  checker verdict for `slv_req_i.aw`. Valid while `aw_valid` is high.
- `ar_allow_i`  in  1  checker verdict for `slv_req_i.ar`. Valid while `ar_valid` is high.
- `deny_cnt_o`  out  `CntWidth`  saturating count of denied AW and AR handshakes.

## Operation

**Write FSM**
- States: W_IDLE, W_FWD, W_DRAIN, W_BERR.
- W_IDLE:
  - Eff_allow = `aw_allow_i & (atop == 0)`.
  - If eff_allow: `mst aw_valid = slv aw_valid`, `slv aw_ready = mst aw_ready`.
  - Else: mst aw_valid = 0, slv aw_ready = 1.
  - On AW handshake, go to W_FWD if allowed, else W_DRAIN. For a denied AW, register id and user.
- W_FWD:
  - W and B are passed through.
  - Return to W_IDLE on the B handshake with upstream.
  - W beats are counted only to check `last`.
- W_DRAIN:
  - slv w_ready = 1 and mst w_valid = 0.
  - On the handshake of the beat with `w.last = 1`, go to W_BERR.
- W_BERR:
  - slv b_valid = 1, `b.id` = registered id, `b.resp = ErrResp`, `b.user` = registered user.
  - Return to W_IDLE on b_ready.
- Outside W_IDLE, slv aw_ready = 0 and mst aw_valid = 0.

**Read FSM**
- States: R_IDLE, R_FWD, R_ERR.
- R_IDLE: same gating as AW, using `ar_allow_i`. A denied AR registers id, user and len.
- R_FWD: R is passed through; return to R_IDLE on the upstream handshake of the `r.last` beat.
- R_ERR:
  - Emit len+1 beats with data = 0, `resp = ErrResp`, registered id and user.
  - The beat counter is 8 bits, counting up from 0.
  - `last = (cnt == len)`. The counter advances only on r_ready.
  - Return to R_IDLE after the last handshake.

**Other rules**
- Outside the forwarding states, all mst channel valids and slv-to-mst readies are 0. B and R from downstream are not forwarded and mst b_ready/r_ready = 0.
- ATOPs are unsupported. A nonzero atop is denied with a B error only. An assertion flags `atop[5]` set.
- Denial counter:
  - Adds (denied AW handshake) + (denied AR handshake), so +2 when both occur in the same cycle.
  - Saturates at all-ones.
- Reset values: W_IDLE, R_IDLE, counter 0, registered id/user/len 0. Outputs then follow the IDLE combinational rules, so all error valids are 0.
- Reset mid-operation aborts any burst. Upstream and downstream are reset in the same domain.

## Timing
- Allowed path: zero-latency combinational pass-through on every channel; no added cycles.
- Denied write: B error valid on the cycle after the W last handshake.
- Denied read: first error R beat valid on the cycle after the AR handshake, then one beat per cycle under continuous r_ready.
- Verdict stability: `aw_allow_i` and `ar_allow_i` must stay stable while their valid is high and not yet handshaken.
- AW and W ordering: W beats arriving before AW is accepted are stalled (w_ready = 0 in W_IDLE).
- Stalling: error B/R valid is held, with stable payload, until ready is asserted.
- Same-direction back-to-back: the next AW/AR is accepted no earlier than the cycle after the FSM returns to IDLE.

## Structure
- All channel types come from `axi_conf`.
- The FSM enums and the default `ErrResp` constant go in a new shared package `axi_io_pmp_pkg`.
- One sub-module, `axi_io_pmp_rd_err`: the R_ERR beat generator (id/user/len capture, counter, last), reusable by other terminating slaves.

## Test plan
- Allowed single-beat write to 0x1000, then read back → identical to a direct connection, deny_cnt_o = 0.
- Denied AW, len = 3, id = 5, followed by 4 W beats → all W accepted, mst sees no valid, one B with id 5 and resp 2'b10, deny_cnt_o = 1.
- Denied AR, len = 7, id = 2, r_ready toggling every other cycle → exactly 8 beats, data 0, resp SLVERR, last only on beat 8, payload stable during stalls.
- Denied AW and denied AR handshaking in the same cycle → deny_cnt_o increments by 2. Counter preset near saturation → holds at all-ones.
- AW with atop = 6'h20 and allow = 1 → treated as denied, B SLVERR, assertion fires.
- Assert rst_i during an R_ERR burst at beat 3 → R valid drops immediately, FSM returns to R_IDLE, counter reset to 0.
